// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO and issue sequencer for the 8-bit combinational ALU (optional ALU_ISSUE_STATS_EN)
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_c_in,
    input  logic [7:0] alu_r,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_op,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0] stat_issued,
    output logic [7:0]  stat_err,
`endif
    output logic       res_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty;
    logic          push, pop;
    logic [7:0]    head_a, head_b;
    logic [2:0]    head_op;
    logic [3:0]    cnt;
    logic          capture_alu, capture_err, handshake;

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign handshake  = res_valid && res_ready;
    assign {head_a, head_b, head_op} = mem[rd_ptr];

    // Command storage; entries need no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // FIFO pointers and occupancy; a push is only visible to pop from the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection; a popped reserved opcode skips the settle wait
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty)
                    state_nxt = (head_op == OP_RSVD) ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == 4'd0) state_nxt = S_OUT;
            end
            S_DONE: state_nxt = S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    if (!fifo_empty)
                        state_nxt = (head_op == OP_RSVD) ? S_DONE : S_SETTLE;
                    else
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes: when to pop the FIFO and when to capture a result
    always_comb begin
        pop         = 1'b0;
        capture_alu = 1'b0;
        capture_err = 1'b0;
        case (state)
            S_IDLE:   pop = !fifo_empty;
            S_SETTLE: capture_alu = (cnt == 4'd0);
            S_DONE:   capture_err = 1'b1;
            S_OUT:    pop = res_ready && !fifo_empty;
            default:  pop = 1'b0;
        endcase
    end

    // ALU operand registers, settle counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_c_in  <= 1'b0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= 1'b0;
        end else begin
            if (pop) begin
                alu_a    <= head_a;
                alu_b    <= head_b;
                alu_op   <= head_op;
                alu_c_in <= (head_op == OP_SUB);
                cnt      <= 4'(SETTLE_CYCLES - 1);
            end else if (state == S_SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (capture_alu) begin
                res_data  <= alu_r;
                res_op    <= alu_op;
                res_err   <= 1'b0;
                res_valid <= 1'b1;
            end else if (capture_err) begin
                res_data  <= '0;
                res_op    <= OP_RSVD;
                res_err   <= 1'b1;
                res_valid <= 1'b1;
            end else if (handshake) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating counters of delivered results and of reserved-opcode results
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_err    <= '0;
        end else if (handshake) begin
            if (stat_issued != '1)        stat_issued <= stat_issued + 16'd1;
            if (res_err && stat_err != '1) stat_err   <= stat_err + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] op;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [2:0] alu_op;
    logic       alu_c_in;
    logic       res_valid, res_ready = 1'b0;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       res_err;

    logic       s4_rst = 1'b1;
    logic       s4_cmd_valid = 1'b0, s4_cmd_ready;
    logic [7:0] s4_cmd_a = '0, s4_cmd_b = '0;
    logic [2:0] s4_cmd_op = '0;
    logic [7:0] s4_alu_a, s4_alu_b, s4_alu_r;
    logic [2:0] s4_alu_op;
    logic       s4_alu_c_in;
    logic       s4_res_valid, s4_res_ready = 1'b1;
    logic [7:0] s4_res_data;
    logic [2:0] s4_res_op;
    logic       s4_res_err;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued, s4_stat_issued;
    logic [7:0]  stat_err, s4_stat_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_hs  = 0;
    exp_t model_q[$];
    exp_t log_q[$];

    always #5 clk = ~clk;

    // Behavioural ALU the DUT drives: two's complement carry chain for add/sub
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op, input logic cin);
        case (op)
            3'd0:    alu_fn = a + b + {7'd0, cin};
            3'd1:    alu_fn = a + ~b + {7'd0, cin};
            3'd2:    alu_fn = a & b;
            3'd3:    alu_fn = a | b;
            3'd4:    alu_fn = a ^ b;
            3'd5:    alu_fn = ~a;
            3'd6:    alu_fn = a << 1;
            default: alu_fn = 8'h5A;
        endcase
    endfunction

    // What the consumer must see for a command, stated arithmetically
    function automatic exp_t expect_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        e.op  = op;
        e.err = 1'b0;
        case (op)
            3'd0: e.d = a + b;
            3'd1: e.d = a - b;
            3'd2: e.d = a & b;
            3'd3: e.d = a | b;
            3'd4: e.d = a ^ b;
            3'd5: e.d = ~a;
            3'd6: e.d = {a[6:0], 1'b0};
            default: begin e.d = 8'h00; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    assign alu_r    = alu_fn(alu_a, alu_b, alu_op, alu_c_in);
    assign s4_alu_r = alu_fn(s4_alu_a, s4_alu_b, s4_alu_op, s4_alu_c_in);

    alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
        .alu_r(alu_r),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued(stat_issued), .stat_err(stat_err),
`endif
        .res_err(res_err)
    );

    alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(4)) dut_s4 (
        .clk(clk), .rst(s4_rst),
        .cmd_valid(s4_cmd_valid), .cmd_ready(s4_cmd_ready),
        .cmd_a(s4_cmd_a), .cmd_b(s4_cmd_b), .cmd_op(s4_cmd_op),
        .alu_a(s4_alu_a), .alu_b(s4_alu_b), .alu_op(s4_alu_op), .alu_c_in(s4_alu_c_in),
        .alu_r(s4_alu_r),
        .res_valid(s4_res_valid), .res_ready(s4_res_ready),
        .res_data(s4_res_data), .res_op(s4_res_op),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued(s4_stat_issued), .stat_err(s4_stat_err),
`endif
        .res_err(s4_res_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and hold it until the FIFO takes it
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int t;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        t = 0;
        while (!cmd_ready && t < 200) begin tick(); t++; end
        if (t >= 200) check("push_timeout", 32'(t), 32'd0);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (model_q.size() != 0 && t < 400) begin tick(); t++; end
        check("drain_empty", 32'(model_q.size()), 32'd0);
    endtask

    // Scoreboard: ordering, content, hold under backpressure and FIFO-ready bounds
    logic       hold_prev = 1'b0;
    logic [7:0] prev_d;
    logic [2:0] prev_op;
    logic       prev_err;
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (model_q.size() < DEPTH) check("cmd_ready_free", {31'd0, cmd_ready}, 32'd1);
            if (model_q.size() > DEPTH) check("cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
            check("c_in_rule", {31'd0, alu_c_in}, {31'd0, (alu_op == 3'd1)});
            if (hold_prev) begin
                check("hold_valid", {31'd0, res_valid}, 32'd1);
                check("hold_data", {24'd0, res_data}, {24'd0, prev_d});
                check("hold_op_err", {28'd0, res_op, res_err}, {28'd0, prev_op, prev_err});
            end
            if (res_valid && res_ready) begin
                if (model_q.size() == 0) begin
                    check("spurious_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = model_q.pop_front();
                    check("res_data", {24'd0, res_data}, {24'd0, e.d});
                    check("res_op", {29'd0, res_op}, {29'd0, e.op});
                    check("res_err", {31'd0, res_err}, {31'd0, e.err});
                end
                log_q.push_back({res_data, res_op, res_err});
                n_hs++;
            end
            if (cmd_valid && cmd_ready) model_q.push_back(expect_fn(cmd_a, cmd_b, cmd_op));
            hold_prev = res_valid && !res_ready;
            prev_d = res_data; prev_op = res_op; prev_err = res_err;
        end
    end

    initial begin
        int base;
        int k;
`ifdef ALU_ISSUE_STATS_EN
        logic [15:0] si0;
        logic [7:0]  se0;
`endif
        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_alu", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
        check("rst_res", {20'd0, res_data, res_op, res_err}, 32'd0);
        rst = 1'b0;
        res_ready = 1'b1;

        // Add: latency and literal result
        push(8'h14, 8'h06, 3'd0);
        check("add_not_yet", {31'd0, res_valid}, 32'd0);
        tick();
        check("add_alu_a", {24'd0, alu_a}, 32'h14);
        check("add_c_in", {31'd0, alu_c_in}, 32'd0);
        check("add_res_valid_early", {31'd0, res_valid}, 32'd0);
        tick();
        check("add_res_valid", {31'd0, res_valid}, 32'd1);
        check("add_res_data", {24'd0, res_data}, 32'h1A);
        check("add_res_op", {29'd0, res_op}, 32'd0);
        tick();

        // Subtract
        push(8'h14, 8'h06, 3'd1);
        tick();
        check("sub_c_in", {31'd0, alu_c_in}, 32'd1);
        tick();
        check("sub_res_data", {24'd0, res_data}, 32'h0E);
        tick();
        drain();

        // Backpressure: one in flight plus a full FIFO
        res_ready = 1'b0;
        base = n_hs;
        for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom), 3'(i));
        tick(); tick();
        check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("bp_held_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        drain();
        check("bp_count", 32'(n_hs - base), 32'd5);

        // Reserved opcode between two adds
        base = n_hs;
`ifdef ALU_ISSUE_STATS_EN
        si0 = stat_issued;
        se0 = stat_err;
`endif
        push(8'h10, 8'h20, 3'd0);
        push(8'hAB, 8'hCD, 3'd7);
        push(8'h80, 8'h7F, 3'd0);
        drain();
        tick();
        check("rsvd_count", 32'(n_hs - base), 32'd3);
        if (n_hs - base == 3) begin
            check("rsvd_first", {20'd0, log_q[base]}, {20'd0, 8'h30, 3'd0, 1'b0});
            check("rsvd_mid", {20'd0, log_q[base+1]}, {20'd0, 8'h00, 3'd7, 1'b1});
            check("rsvd_last", {20'd0, log_q[base+2]}, {20'd0, 8'hFF, 3'd0, 1'b0});
        end
`ifdef ALU_ISSUE_STATS_EN
        check("stat_issued", 32'(stat_issued - si0), 32'd3);
        check("stat_err", 32'(stat_err - se0), 32'd1);
`endif

        // Randomized traffic with random backpressure
        for (int c = 0; c < 800; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 3'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain();

        // Mid-operation reset with commands queued
        res_ready = 1'b0;
        push(8'h01, 8'h02, 3'd0);
        push(8'h03, 8'h04, 3'd2);
        push(8'h05, 8'h06, 3'd3);
        rst = 1'b1;
        tick();
        check("mrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mrst_alu", {12'd0, alu_a, alu_b, alu_op, alu_c_in}, 32'd0);
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mrst_no_stale", {31'd0, res_valid}, 32'd0);
        end

        // SETTLE_CYCLES=4 instance: stable operands and five-cycle latency
        s4_rst = 1'b1;
        tick(); tick();
        s4_rst = 1'b0;
        s4_cmd_valid = 1'b1; s4_cmd_a = 8'h21; s4_cmd_b = 8'h13; s4_cmd_op = 3'd0;
        check("s4_ready", {31'd0, s4_cmd_ready}, 32'd1);
        tick();
        s4_cmd_valid = 1'b0;
        for (k = 1; k <= 5; k++) begin
            tick();
            check("s4_alu_stable", {16'd0, s4_alu_a, s4_alu_b}, 32'h2113);
            check("s4_res_valid", {31'd0, s4_res_valid}, {31'd0, (k == 5)});
        end
        check("s4_res_data", {24'd0, s4_res_data}, 32'h34);
        tick();

        // SETTLE_CYCLES=4 instance: reset while settling with two queued
        for (int i = 0; i < 3; i++) begin
            s4_cmd_valid = 1'b1; s4_cmd_a = 8'(i + 1); s4_cmd_b = 8'h01; s4_cmd_op = 3'd0;
            tick();
        end
        s4_cmd_valid = 1'b0;
        s4_rst = 1'b1;
        tick();
        check("s4_mrst_valid", {31'd0, s4_res_valid}, 32'd0);
        check("s4_mrst_ready", {31'd0, s4_cmd_ready}, 32'd1);
        check("s4_mrst_alu", {12'd0, s4_alu_a, s4_alu_b, s4_alu_op, s4_alu_c_in}, 32'd0);
        s4_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s4_no_stale", {31'd0, s4_res_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
